// File: rtl/multi_strategy_engine.sv
// Strategy engine: per-symbol last-price table, spread/momentum tick decisions,
// a sliced TWAP scheduler and an order FIFO where tick orders take priority over TWAP slices.
module multi_strategy_engine #(
    parameter int SYMBOL_WIDTH = 32,
    parameter int PRICE_WIDTH  = 32,
    parameter int VOLUME_WIDTH = 32,
    parameter int SYM_IDX_BITS = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int MOM_SHIFT    = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_valid,
    input  logic [SYMBOL_WIDTH-1:0] tick_symbol,
    input  logic [PRICE_WIDTH-1:0]  tick_price,
    input  logic [PRICE_WIDTH-1:0]  tick_bid,
    input  logic [PRICE_WIDTH-1:0]  tick_ask,
    input  logic [2:0]              strategy_enable,
    input  logic [PRICE_WIDTH-1:0]  spread_min,
    input  logic [VOLUME_WIDTH-1:0] order_qty,
    input  logic                    twap_start,
    input  logic                    twap_abort,
    input  logic [SYMBOL_WIDTH-1:0] twap_symbol,
    input  logic                    twap_side,
    input  logic [VOLUME_WIDTH-1:0] twap_target_vol,
    input  logic [VOLUME_WIDTH-1:0] twap_slice_vol,
    input  logic [31:0]             twap_interval,
    output logic                    order_valid,
    input  logic                    order_ready,
    output logic [SYMBOL_WIDTH-1:0] order_symbol,
    output logic [PRICE_WIDTH-1:0]  order_price,
    output logic [VOLUME_WIDTH-1:0] order_volume,
    output logic                    order_side,
    output logic [2:0]              order_type,
    output logic [1:0]              order_strategy,
    output logic                    twap_busy,
    output logic                    twap_done,
    output logic [VOLUME_WIDTH-1:0] twap_executed,
    output logic [31:0]             decisions_made,
    output logic [31:0]             orders_generated,
    output logic [31:0]             orders_dropped
);
    localparam int NSYM  = 1 << SYM_IDX_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [SYMBOL_WIDTH-1:0] symbol;
        logic [PRICE_WIDTH-1:0]  price;
        logic [VOLUME_WIDTH-1:0] volume;
        logic                    side;
        logic [2:0]              otype;
        logic [1:0]              strat;
    } order_t;

    typedef enum logic {TW_IDLE = 1'b0, TW_RUN = 1'b1} tw_state_t;

    logic [PRICE_WIDTH-1:0]  tbl_price_q [NSYM];
    logic [NSYM-1:0]         tbl_valid_q;
    logic                    s1_valid_q, s1_last_vld_q;
    logic [SYMBOL_WIDTH-1:0] s1_sym_q;
    logic [PRICE_WIDTH-1:0]  s1_price_q, s1_bid_q, s1_ask_q, s1_last_q;
    logic                    s2_valid_q;
    order_t                  s2_ord_q;
    order_t                  fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    tw_state_t               tw_state_q;
    logic [SYMBOL_WIDTH-1:0] tw_sym_q;
    logic                    tw_side_q, tw_pend_q, tw_done_q;
    logic [VOLUME_WIDTH-1:0] tw_target_q, tw_slice_q, tw_exec_q;
    logic [31:0]             tw_interval_q, tw_timer_q;

    logic [SYM_IDX_BITS-1:0] tick_idx_s, s1_idx_s, tw_idx_s;
    logic                    fwd_s, dec_hit_s, pop_s, space_s, tick_push_s, tick_drop_s;
    logic                    slice_push_s, push_s, tw_stop_s, tw_wrap_s;
    logic [PRICE_WIDTH-1:0]  spread_s, mom_diff_s, mom_thr_s;
    logic [VOLUME_WIDTH-1:0] tw_remain_s, tw_vol_s;
    order_t                  dec_ord_s, slice_ord_s, push_ord_s, head_s;

    assign tick_idx_s = tick_symbol[SYM_IDX_BITS-1:0];
    assign s1_idx_s   = s1_sym_q[SYM_IDX_BITS-1:0];
    assign tw_idx_s   = tw_sym_q[SYM_IDX_BITS-1:0];
    // The S2 table write lands on the same edge S1 reads, so bypass it.
    assign fwd_s      = s1_valid_q && (s1_idx_s == tick_idx_s);

    // S1: capture the tick and its table entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sym_q      <= '0;
            s1_price_q    <= '0;
            s1_bid_q      <= '0;
            s1_ask_q      <= '0;
            s1_last_q     <= '0;
            s1_last_vld_q <= 1'b0;
        end else begin
            s1_valid_q <= tick_valid;
            if (tick_valid) begin
                s1_sym_q      <= tick_symbol;
                s1_price_q    <= tick_price;
                s1_bid_q      <= tick_bid;
                s1_ask_q      <= tick_ask;
                s1_last_q     <= fwd_s ? s1_price_q : tbl_price_q[tick_idx_s];
                s1_last_vld_q <= fwd_s | tbl_valid_q[tick_idx_s];
            end
        end
    end

    // Spread-then-momentum decision on the S1 tick
    always_comb begin
        dec_hit_s        = 1'b0;
        dec_ord_s        = '0;
        dec_ord_s.symbol = s1_sym_q;
        dec_ord_s.volume = order_qty;
        spread_s         = s1_ask_q - s1_bid_q;
        mom_thr_s        = s1_last_q >> MOM_SHIFT;
        if (s1_price_q > s1_last_q) begin
            mom_diff_s = s1_price_q - s1_last_q;
        end else begin
            mom_diff_s = s1_last_q - s1_price_q;
        end
        if (!s1_valid_q) begin
            dec_hit_s = 1'b0;
        end else if (strategy_enable[0] && (s1_ask_q > s1_bid_q) && (spread_s >= spread_min)) begin
            dec_hit_s       = 1'b1;
            dec_ord_s.price = s1_bid_q;
            dec_ord_s.side  = 1'b0;
            dec_ord_s.otype = 3'd1;
            dec_ord_s.strat = 2'd0;
        end else if (strategy_enable[1] && s1_last_vld_q && (mom_diff_s > mom_thr_s)) begin
            dec_hit_s       = 1'b1;
            dec_ord_s.price = s1_price_q;
            dec_ord_s.side  = (s1_price_q < s1_last_q);
            dec_ord_s.otype = 3'd0;
            dec_ord_s.strat = 2'd1;
        end else begin
            dec_hit_s = 1'b0;
        end
    end

    // S2: register the decision and update the last-price table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_ord_q    <= '0;
            tbl_valid_q <= '0;
            for (int i = 0; i < NSYM; i++) tbl_price_q[i] <= '0;
        end else begin
            s2_valid_q <= dec_hit_s;
            s2_ord_q   <= dec_ord_s;
            if (s1_valid_q) begin
                tbl_price_q[s1_idx_s] <= s1_price_q;
                tbl_valid_q[s1_idx_s] <= 1'b1;
            end
        end
    end

    assign pop_s        = (count_q != '0) && order_ready;
    assign space_s      = (count_q != FIFO_FULL) || pop_s;
    assign tick_push_s  = s2_valid_q && space_s;
    assign tick_drop_s  = s2_valid_q && !space_s;
    assign tw_stop_s    = twap_abort || !strategy_enable[2];
    assign tw_wrap_s    = (tw_timer_q == (tw_interval_q - 32'd1));
    assign tw_remain_s  = tw_target_q - tw_exec_q;
    assign tw_vol_s     = (tw_slice_q < tw_remain_s) ? tw_slice_q : tw_remain_s;
    assign slice_push_s = (tw_state_q == TW_RUN) && tw_pend_q && !tw_stop_s && !s2_valid_q && space_s;
    assign push_s       = tick_push_s || slice_push_s;

    // Slice order contents and push-source selection
    always_comb begin
        slice_ord_s        = '0;
        slice_ord_s.symbol = tw_sym_q;
        slice_ord_s.price  = tbl_valid_q[tw_idx_s] ? tbl_price_q[tw_idx_s] : '0;
        slice_ord_s.volume = tw_vol_s;
        slice_ord_s.side   = tw_side_q;
        slice_ord_s.otype  = 3'd0;
        slice_ord_s.strat  = 2'd2;
        if (tick_push_s) begin
            push_ord_s = s2_ord_q;
        end else begin
            push_ord_s = slice_ord_s;
        end
    end

    // Order FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= push_ord_s;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // TWAP scheduler FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_state_q    <= TW_IDLE;
            tw_sym_q      <= '0;
            tw_side_q     <= 1'b0;
            tw_target_q   <= '0;
            tw_slice_q    <= '0;
            tw_interval_q <= '0;
            tw_timer_q    <= '0;
            tw_exec_q     <= '0;
            tw_pend_q     <= 1'b0;
            tw_done_q     <= 1'b0;
        end else begin
            tw_done_q <= 1'b0;
            case (tw_state_q)
                TW_IDLE: begin
                    if (twap_start && strategy_enable[2] && (twap_target_vol != '0) && (twap_interval != 32'd0)) begin
                        tw_state_q    <= TW_RUN;
                        tw_sym_q      <= twap_symbol;
                        tw_side_q     <= twap_side;
                        tw_target_q   <= twap_target_vol;
                        tw_slice_q    <= twap_slice_vol;
                        tw_interval_q <= twap_interval;
                        tw_timer_q    <= 32'd0;
                        tw_exec_q     <= '0;
                        tw_pend_q     <= 1'b0;
                    end
                end
                TW_RUN: begin
                    if (tw_stop_s) begin
                        tw_state_q <= TW_IDLE;
                        tw_pend_q  <= 1'b0;
                    end else begin
                        tw_timer_q <= tw_wrap_s ? 32'd0 : tw_timer_q + 32'd1;
                        // A new due slice wins over clearing the one just issued.
                        if (tw_wrap_s) tw_pend_q <= 1'b1;
                        else if (slice_push_s) tw_pend_q <= 1'b0;
                        if (slice_push_s) begin
                            tw_exec_q <= tw_exec_q + tw_vol_s;
                            if (tw_vol_s == tw_remain_s) begin
                                tw_done_q  <= 1'b1;
                                tw_state_q <= TW_IDLE;
                                tw_pend_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: tw_state_q <= TW_IDLE;
            endcase
        end
    end

    // Wrapping activity counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decisions_made   <= 32'd0;
            orders_generated <= 32'd0;
            orders_dropped   <= 32'd0;
        end else begin
            decisions_made   <= decisions_made + 32'(s1_valid_q);
            orders_generated <= orders_generated + 32'(push_s);
            orders_dropped   <= orders_dropped + 32'(tick_drop_s);
        end
    end

    assign head_s         = fifo_mem_q[rd_ptr_q];
    assign order_valid    = (count_q != '0);
    assign order_symbol   = head_s.symbol;
    assign order_price    = head_s.price;
    assign order_volume   = head_s.volume;
    assign order_side     = head_s.side;
    assign order_type     = head_s.otype;
    assign order_strategy = head_s.strat;
    assign twap_busy      = (tw_state_q == TW_RUN);
    assign twap_done      = tw_done_q;
    assign twap_executed  = tw_exec_q;
endmodule
